// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for mem_bus_arbiter
package mem_arb_pkg;

  // Bus ownership phases of the arbiter
  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    RETURN  = 2'd2
  } arb_state_e;

  // Which requester drives the memory address/data/strobe
  typedef enum logic {
    SEL_CPU = 1'b0,
    SEL_DMA = 1'b1
  } owner_sel_e;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'hE000;

  // Counter width able to hold 0..maxval, never narrower than one bit
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - core/DMA/memory bus bundle around the arbiter
interface mem_bus_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic        cpu_rdy;
  logic [7:0]  cpu_rd_data;
  logic        dma_req;
  logic [15:0] dma_address;
  logic [7:0]  dma_wr_data;
  logic        dma_wr_enable;
  logic        dma_gnt;
  logic        dma_rd_valid;
  logic [7:0]  dma_rd_data;
  logic [15:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_enable;
  logic [7:0]  mem_rd_data;
  logic        dma_wr_err;

  // Arbiter side
  modport slave (
    input  cpu_address, cpu_wr_data, cpu_wr_enable,
    input  dma_req, dma_address, dma_wr_data, dma_wr_enable,
    input  mem_rd_data,
    output cpu_rdy, cpu_rd_data,
    output dma_gnt, dma_rd_valid, dma_rd_data,
    output mem_address, mem_wr_data, mem_wr_enable,
    output dma_wr_err
  );

  // Core, DMA and memory side
  modport master (
    output cpu_address, cpu_wr_data, cpu_wr_enable,
    output dma_req, dma_address, dma_wr_data, dma_wr_enable,
    output mem_rd_data,
    input  cpu_rdy, cpu_rd_data,
    input  dma_gnt, dma_rd_valid, dma_rd_data,
    input  mem_address, mem_wr_data, mem_wr_enable,
    input  dma_wr_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - core/DMA memory port arbiter; MEM_ARB_ROM_PROTECT_EN adds DMA ROM write protect
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST      = 4,
  parameter int MIN_CPU_CYCLES = 2
`ifdef MEM_ARB_ROM_PROTECT_EN
  ,
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int CW = cnt_width(MIN_CPU_CYCLES);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          rd_valid_q, rd_valid_d;
  logic          xfer;
  logic          dma_we_ok;
  owner_sel_e    sel;

  // A transfer happens on every granted cycle where the DMA side is valid
  assign xfer = (state_q == DMA_OWN) && bus.dma_req;

`ifdef MEM_ARB_ROM_PROTECT_EN
  logic rom_hit;
  logic wr_err_q;

  // DMA writes into ROM still count as transfers but never reach memory
  assign rom_hit   = bus.dma_wr_enable && (bus.dma_address >= ROM_BASE);
  assign dma_we_ok = xfer && bus.dma_wr_enable && !rom_hit;

  // Sticky ROM write violation flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else if (xfer && rom_hit) begin
      wr_err_q <= 1'b1;
    end
  end

  assign bus.dma_wr_err = wr_err_q;
`else
  assign dma_we_ok      = xfer && bus.dma_wr_enable;
  assign bus.dma_wr_err = 1'b0;
`endif

  // State, counters and read-valid pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CPU_OWN;
      burst_q    <= '0;
      cool_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      cool_q     <= cool_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state: grant only between core writes, bound bursts, then replay core read
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    cool_d     = cool_q;
    rd_valid_d = xfer && !bus.dma_wr_enable;
    case (state_q)
      CPU_OWN: begin
        if (cool_q != '0) begin
          cool_d = cool_q - CW'(1);
        end
        if (bus.dma_req && !bus.cpu_wr_enable && (cool_q == '0)) begin
          state_d = DMA_OWN;
        end
      end
      DMA_OWN: begin
        if (!bus.dma_req) begin
          state_d = RETURN;
        end else begin
          if (burst_q != BW'(MAX_BURST)) begin
            burst_d = burst_q + BW'(1);
          end
          if (burst_q == BW'(MAX_BURST - 1)) begin
            state_d = RETURN;
          end
        end
      end
      RETURN: begin
        cool_d  = CW'(MIN_CPU_CYCLES);
        burst_d = '0;
        state_d = CPU_OWN;
      end
      default: begin
        state_d = CPU_OWN;
      end
    endcase
  end

  // Memory mux driven from registered ownership; RETURN re-reads the held core address
  always_comb begin
    sel               = (state_q == DMA_OWN) ? SEL_DMA : SEL_CPU;
    bus.mem_address   = (sel == SEL_DMA) ? bus.dma_address : bus.cpu_address;
    bus.mem_wr_data   = (sel == SEL_DMA) ? bus.dma_wr_data : bus.cpu_wr_data;
    bus.mem_wr_enable = 1'b0;
    case (state_q)
      CPU_OWN: bus.mem_wr_enable = bus.cpu_wr_enable;
      DMA_OWN: bus.mem_wr_enable = dma_we_ok;
      default: bus.mem_wr_enable = 1'b0;
    endcase
  end

  assign bus.cpu_rdy      = (state_q == CPU_OWN);
  assign bus.dma_gnt      = (state_q == DMA_OWN);
  assign bus.dma_rd_valid = rd_valid_q;
  assign bus.cpu_rd_data  = bus.mem_rd_data;
  assign bus.dma_rd_data  = bus.mem_rd_data;

endmodule
